md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multi-cycle sequencer for the multiply/divide unit attached to the single-issue processor datapath.
- Detects R-type mul/div in decode and stalls the PC/fetch path.
- Issues a one-cycle start pulse to the multdiv unit, waits for its ready handshake, then drives the register-file writeback.
- Writeback targets either rd or, on an exception, rstatus ($r30) with a status code.

Parameters:
- OP_RTYPE, 5'd0, opcode value of R-type instructions.
- ALUOP_MUL, 5'd6, ALUop field encoding multiply.
- ALUOP_DIV, 5'd7, ALUop field encoding divide.
- TIMEOUT_CYCLES, 40, max WAIT cycles before forced abort (used only with MD_TIMEOUT_EN).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- instr_valid  in  1  decode-stage instruction valid.
- opcode  in  5  decode-stage opcode.
- aluop  in  5  decode-stage ALUop field.
- rd  in  5  decode-stage destination register.
- md_rdy  in  1  multdiv result ready (data_resultRDY).
- md_exception  in  1  multdiv exception (overflow / divide-by-zero), sampled with md_rdy.
- stall  out  1  hold PC and decode register.
- ctrl_mult  out  1  one-cycle multiply start pulse.
- ctrl_div  out  1  one-cycle divide start pulse.
- wb_en  out  1  register-file write enable for the md result.
- wb_sel_rstatus  out  1  1 = write rstatus_val instead of the md result.
- wb_addr  out  5  writeback register index.
- rstatus_val  out  32  status code written on exception.

Behaviour:
- md_detect (combinational) = instr_valid & opcode==OP_RTYPE & (aluop==ALUOP_MUL | aluop==ALUOP_DIV).
- States: IDLE, START, WAIT, WB. Encoding is free; must be registered.
- Reset (reset low, any state, including mid-operation): state=IDLE, latched op/rd=0, counter=0.
  - All registered outputs are 0.
  - stall still follows md_detect combinationally.
  - No start pulse or write may escape after reset asserts.
- IDLE:
  - stall = md_detect.
  - If md_detect: latch is_div=(aluop==ALUOP_DIV) and rd, then go to START.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - stall=1; ctrl_mult=~is_div, ctrl_div=is_div; counter cleared.
  - md_rdy is ignored here (it may be stale from the previous op). Go to WAIT.
- WAIT:
  - stall=1; counter increments each cycle, saturating.
  - md_rdy=1 → capture exc=md_exception, go to WB.
- WB (exactly 1 cycle):
  - stall=0, so the PC advances at the end of this cycle.
  - exc=0: wb_en=(rd!=0), wb_sel_rstatus=0, wb_addr=latched rd.
  - exc=1: wb_en=1, wb_sel_rstatus=1, wb_addr=5'd30, rstatus_val = 4 (mul) or 5 (div).
  - Then go to IDLE.
  - md_detect is not evaluated in WB; the next instruction is evaluated in the following IDLE cycle.
- Output rules:
  - ctrl_mult/ctrl_div are never both 1 and are high for exactly one cycle per operation.
  - wb_en is high for exactly one cycle per operation.
  - rstatus_val = 0 whenever wb_sel_rstatus = 0.
- Latency: detect cycle + START + N WAIT cycles + WB, where N ≥ 1 is the number of cycles until md_rdy.
- Back-to-back mul/div: the second one is detected in the IDLE cycle after WB, which adds one bubble.

Optional Feature:
- Macro: MD_TIMEOUT_EN.
- Defined:
  - In WAIT, if the counter reaches TIMEOUT_CYCLES with md_rdy=0, go to WB with exc forced to 1 and rstatus_val=6.
  - A late md_rdy after the abort is ignored in IDLE.
- Undefined:
  - The counter logic is absent; WAIT lasts until md_rdy, with no bound.

Test Plan:
- mul, rd=3, md_rdy after 5 WAIT cycles, no exception → ctrl_mult pulses once in START; stall high from detect through WAIT; in WB wb_en=1, wb_addr=3, wb_sel_rstatus=0; total 8 cycles.
- div, rd=7, md_exception=1 with md_rdy → ctrl_div pulse; WB writes wb_addr=30, wb_sel_rstatus=1, rstatus_val=5.
- mul, rd=0, no exception → wb_en=0 in WB, stall still released; with md_exception=1 → wb_addr=30, rstatus_val=4.
- Stale md_rdy=1 held high during START → ignored; WB occurs only after the first WAIT cycle; back-to-back div then mul → exactly one bubble IDLE cycle between.
- reset driven low during WAIT → outputs 0 asynchronously; after release, state is IDLE and no wb_en pulse from the aborted op.
- MD_TIMEOUT_EN, TIMEOUT_CYCLES=4, md_rdy never asserted → WB after 4 WAIT cycles: wb_addr=30, rstatus_val=6; a later md_rdy produces no write.

Source files
------------

// File: rtl/md_sequencer.sv
// Multi-cycle mul/div sequencer: stalls fetch, pulses the multdiv start, waits for ready, drives writeback.
// Latency: detect cycle + START + N WAIT cycles + WB (WAIT bounded by TIMEOUT_CYCLES when MD_TIMEOUT_EN).
// Backpressure: stall held from detect through WAIT, released in WB; md_rdy ignored outside WAIT.
module md_sequencer #(
    parameter logic [4:0] OP_RTYPE       = 5'd0,
    parameter logic [4:0] ALUOP_MUL      = 5'd6,
    parameter logic [4:0] ALUOP_DIV      = 5'd7,
    parameter int         TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [4:0]  opcode,
    input  logic [4:0]  aluop,
    input  logic [4:0]  rd,
    input  logic        md_rdy,
    input  logic        md_exception,
    output logic        stall,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        wb_en,
    output logic        wb_sel_rstatus,
    output logic [4:0]  wb_addr,
    output logic [31:0] rstatus_val
);

    typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

    state_t      state, state_nxt;
    logic        is_div, exc, tmo;
    logic [4:0]  rd_q;
    logic        md_detect, latch_op, timeout_hit;

    assign md_detect = instr_valid && (opcode == OP_RTYPE) &&
                       ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));

`ifdef MD_TIMEOUT_EN
    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  TMO_MAX  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    assign timeout_hit = (state == WAIT) && (cnt == TMO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            if (state == START) begin
                cnt <= '0;
            end else if ((state == WAIT) && (cnt != TMO_MAX)) begin
                cnt <= cnt + 1'b1;
            end
            if (state == WAIT) begin
                tmo <= !md_rdy && timeout_hit;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign tmo         = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        stall          = 1'b0;
        ctrl_mult      = 1'b0;
        ctrl_div       = 1'b0;
        wb_en          = 1'b0;
        wb_sel_rstatus = 1'b0;
        wb_addr        = 5'd0;
        rstatus_val    = 32'd0;
        latch_op       = 1'b0;
        case (state)
            IDLE: begin
                stall = md_detect;
                if (md_detect) begin
                    latch_op  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                // md_rdy may still be high from the previous op, so it is not looked at here
                stall     = 1'b1;
                ctrl_mult = !is_div;
                ctrl_div  = is_div;
                state_nxt = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (md_rdy || timeout_hit) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                if (exc) begin
                    wb_en          = 1'b1;
                    wb_sel_rstatus = 1'b1;
                    wb_addr        = 5'd30;
                    rstatus_val    = tmo ? 32'd6 : (is_div ? 32'd5 : 32'd4);
                end else begin
                    wb_en   = |rd_q;
                    wb_addr = rd_q;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            is_div <= 1'b0;
            rd_q   <= 5'd0;
            exc    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_op) begin
                is_div <= (aluop == ALUOP_DIV);
                rd_q   <= rd;
            end
            if (state == WAIT) begin
                if (md_rdy) begin
                    exc <= md_exception;
                end else if (timeout_hit) begin
                    exc <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus queues expected start/writeback events, a monitor checks them.
// Latency: checks are sampled at negedge or 1 time unit after posedge.
// Backpressure: the monitor flags any start/write/stall-release event not present in the queue.
module tb_md_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid, md_rdy, md_exception;
    logic [4:0]  opcode, aluop, rd;
    logic        stall, ctrl_mult, ctrl_div, wb_en, wb_sel_rstatus;
    logic [4:0]  wb_addr;
    logic [31:0] rstatus_val;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [15:0] cyc;
        logic        mult;
        logic        div;
        logic        en;
        logic        sel;
        logic [4:0]  addr;
        logic [31:0] rst;
    } ev_t;

    ev_t exp_q[$];

    md_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .aluop(aluop), .rd(rd), .md_rdy(md_rdy), .md_exception(md_exception),
        .stall(stall), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .wb_en(wb_en),
        .wb_sel_rstatus(wb_sel_rstatus), .wb_addr(wb_addr), .rstatus_val(rstatus_val)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any start pulse, write, or stall release is an event that must match the queue head.
    initial begin
        logic prev_stall;
        ev_t  act, e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                check("never_both_starts", 64'(ctrl_mult & ctrl_div), 64'd0);
                check("rstatus_zero_unsel", 64'(!wb_sel_rstatus && (rstatus_val != 0)), 64'd0);
                if (ctrl_mult || ctrl_div || wb_en || (prev_stall && !stall)) begin
                    act.cyc  = 16'(cyc);
                    act.mult = ctrl_mult;
                    act.div  = ctrl_div;
                    act.en   = wb_en;
                    act.sel  = wb_sel_rstatus;
                    act.addr = wb_addr;
                    act.rst  = rstatus_val;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got %0h expected none", act);
                    end else begin
                        e = exp_q.pop_front();
                        check("event", 64'(act), 64'(e));
                    end
                end
                prev_stall = stall;
            end
        end
    end

    task automatic run_op(input bit div, input logic [4:0] rdv, input int n, input bit exc,
                          input bit stale, input bit tmo, input bit nxt_vld, input bit nxt_div,
                          input logic [4:0] nxt_rd);
        int  d = cyc;
        ev_t s, w;
        instr_valid = 1'b1;
        opcode      = 5'd0;
        aluop       = div ? 5'd7 : 5'd6;
        rd          = rdv;
        s.cyc = 16'(d + 1); s.mult = !div; s.div = div; s.en = 1'b0; s.sel = 1'b0;
        s.addr = 5'd0; s.rst = 32'd0;
        w.cyc = 16'(d + n + 2); w.mult = 1'b0; w.div = 1'b0;
        if (exc || tmo) begin
            w.en = 1'b1; w.sel = 1'b1; w.addr = 5'd30;
            w.rst = tmo ? 32'd6 : (div ? 32'd5 : 32'd4);
        end else begin
            w.en = (rdv != 5'd0); w.sel = 1'b0; w.addr = rdv; w.rst = 32'd0;
        end
        exp_q.push_back(s);
        exp_q.push_back(w);
        @(negedge clock) check("stall_detect", 64'(stall), 64'd1);
        @(posedge clock) #1;
        md_rdy       = stale;
        md_exception = 1'b0;
        @(negedge clock) check("stall_start", 64'(stall), 64'd1);
        for (int i = 1; i <= n; i++) begin
            @(posedge clock) #1;
            md_rdy       = !tmo && (i == n);
            md_exception = exc && (i == n);
            @(negedge clock) check("stall_wait", 64'(stall), 64'd1);
        end
        @(posedge clock) #1;
        md_rdy       = 1'b0;
        md_exception = 1'b0;
        instr_valid  = nxt_vld;
        aluop        = nxt_div ? 5'd7 : 5'd6;
        rd           = nxt_rd;
        @(negedge clock) check("stall_wb", 64'(stall), 64'd0);
        @(posedge clock) #1;
    endtask

    // Starts a mul to rd=9 and pulls reset after `waits` WAIT cycles (0 = during START).
    task automatic rst_abort(input int waits);
        int  d = cyc;
        ev_t s;
        instr_valid = 1'b1;
        opcode      = 5'd0;
        aluop       = 5'd6;
        rd          = 5'd9;
        if (waits > 0) begin
            s.cyc = 16'(d + 1); s.mult = 1'b1; s.div = 1'b0; s.en = 1'b0; s.sel = 1'b0;
            s.addr = 5'd0; s.rst = 32'd0;
            exp_q.push_back(s);
        end
        @(posedge clock) #1;
        check("start_before_rst", 64'(ctrl_mult), 64'd1);
        for (int i = 0; i < waits; i++) @(posedge clock) #1;
        reset = 1'b0;
        #1;
        check("rst_async_outputs", 64'({ctrl_mult, ctrl_div, wb_en, wb_sel_rstatus, wb_addr, rstatus_val}), 64'd0);
        check("rst_stall_follows_detect", 64'(stall), 64'd1);
        instr_valid = 1'b0;
        #1;
        check("rst_stall_drops", 64'(stall), 64'd0);
        @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock) #1;
        md_rdy = 1'b1;
        repeat (3) @(posedge clock);
        #1 md_rdy = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; instr_valid = 1'b0; opcode = 5'd0; aluop = 5'd0; rd = 5'd0;
        md_rdy = 1'b0; md_exception = 1'b0;
        #2;
        check("reset_outputs", 64'({ctrl_mult, ctrl_div, wb_en, wb_sel_rstatus, wb_addr, rstatus_val, stall}), 64'd0);
        instr_valid = 1'b1; aluop = 5'd6;
        #1 check("reset_stall_comb", 64'(stall), 64'd1);
        instr_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock) #1;

        run_op(1'b0, 5'd3,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);  // mul rd=3, 8 cycles total
        run_op(1'b1, 5'd7,  3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);  // div exception -> rstatus 5
        run_op(1'b0, 5'd0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);  // rd=0: no write
        run_op(1'b0, 5'd0,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);  // mul exception -> rstatus 4
        run_op(1'b1, 5'd12, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4);  // stale rdy, then back-to-back mul
        run_op(1'b0, 5'd4,  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        run_op(1'b1, 5'd5,  1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);  // stale rdy with single WAIT cycle

        rst_abort(0);
        rst_abort(2);

`ifdef MD_TIMEOUT_EN
        run_op(1'b0, 5'd5, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);   // no md_rdy: abort after 4 WAITs
        md_rdy = 1'b1;
        repeat (3) @(posedge clock);
        #1 md_rdy = 1'b0;
`else
        run_op(1'b0, 5'd2, 45, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);  // WAIT has no bound
`endif

        repeat (4) @(posedge clock);
        #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
